imem_fetch_ctrl: RTL
====================

// Module: imem_fetch_ctrl
// PURPOSE
//  Fetch sequencer for the word-indexed combinational instruction ROM (imem): owns the PC,
//  drives imem address, buffers fetched words in a 2-entry skid FIFO and hands them to the
//  decode stage with valid/ready. Handles branch/jump redirects (flush), halt and end-of-ROM.
//  Sits between imem and the IF/ID pipeline register of the pipelined processor.
// PARAMETERS
//  IMEM_DEPTH  400  number of 32-bit words in imem; legal PC range 0..IMEM_DEPTH-1
//  RESET_PC    0    PC loaded on reset (word index, not byte address)
//  FIFO_DEPTH  2    fetch buffer entries; fixed at 2, other values unsupported
// PORTS
//  clk             in   1   single clock, all state on rising edge
//  rst_n           in   1   asynchronous reset, active-low
//  imem_pc         out  32  word index to imem; imem_instr valid same cycle (comb ROM)
//  imem_instr      in   32  instruction read from imem[imem_pc]
//  dec_valid       out  1   head FIFO entry valid for decode
//  dec_ready       in   1   decode accepts head this cycle (pop when dec_valid&&dec_ready)
//  dec_instr       out  32  head instruction
//  dec_pc          out  32  word index of head instruction
//  redirect_valid  in   1   taken branch/jump from EX: flush and restart at redirect_pc
//  redirect_pc     in   32  redirect target (word index)
//  halt_req        in   1   stop fetching after current cycle
//  halted          out  1   1 while state==HALT
//  pc_fault        out  1   sticky: redirect target >= IMEM_DEPTH; cleared by reset only
// BEHAVIOUR
//  Reset (async assert, sync release): pc=RESET_PC, FIFO empty, state=RUN, dec_valid=0,
//   dec_instr=0, dec_pc=0, halted=0, pc_fault=0; imem_pc = pc at all times (combinational).
//  States: RUN (fetch enabled), HALT (fetch disabled, FIFO keeps draining).
//  Push in RUN: when count<2 or a pop occurs same cycle -> push {pc, imem_instr}, pc<=pc+1.
//   Simultaneous push+pop: count unchanged, order preserved (FIFO, head = oldest).
//  dec_valid = (count!=0); dec_instr/dec_pc = head entry; no combinational path from
//   imem_instr or dec_ready to dec_* outputs.
//  Latency: first word at RESET_PC visible on dec_* 1 cycle after reset release.
//  Redirect (highest priority, any state): FIFO cleared, no push, pop ignored that cycle;
//   if redirect_pc < IMEM_DEPTH -> pc<=redirect_pc, state<=RUN; target word on dec_* at
//   redirect cycle+2 (imem_pc=target at +1). Else -> pc unchanged, state<=HALT, pc_fault<=1.
//  halt_req (no redirect): state<=HALT at next edge; the push in the halt_req cycle still
//   occurs if allowed. halt_req in HALT: no effect.
//  End of ROM: push of pc==IMEM_DEPTH-1 -> pc holds at IMEM_DEPTH-1, state<=HALT (no wrap).
//  Backpressure: dec_ready=0 with FIFO full -> pc and FIFO frozen, no word dropped/duplicated.
//  Reset mid-operation: all state returns to reset values immediately (asynchronous).
// CONFIGURATION
//  FETCH_PERF_CNT_EN defined: adds outputs perf_fetch_cnt[31:0] (pushes) and
//   perf_stall_cnt[31:0] (RUN cycles with no push); both reset to 0, wrap at 2^32, never
//   cleared by redirect. Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  Reset release, dec_ready=1, imem[i]=i+0x100 -> dec_instr 0x100,0x101,... dec_pc 0,1,2 one/cycle
//  dec_ready=0 for 5 cycles then 1 -> count stays 2, imem_pc frozen, no gap/duplicate after
//  redirect_valid=1,redirect_pc=40 while full -> dec_valid=0 next cycle, dec_pc=40 at cycle+2
//  RESET_PC=397, dec_ready=1 -> dec_pc 397,398,399 then halted=1, dec_valid=0, imem_pc=399
//  redirect_pc=400 -> pc_fault=1, halted=1; then redirect_pc=5 -> RUN, dec_pc=5, pc_fault stays 1
//  FETCH_PERF_CNT_EN: 10 cycles run with 3-cycle stall window -> perf_fetch_cnt/stall_cnt match

Source files
------------

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: PC, imem addressing, 2-entry fetch buffer to decode; first word on dec_* 1 cycle after reset.
// Decode backpressure freezes PC and buffer when full; FETCH_PERF_CNT_EN adds fetch/stall counters.

module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  parameter int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic [CNT_W-1:0] count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      // Storage is left as-is; only the occupancy is discarded.
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module imem_fetch_ctrl #(
  parameter int IMEM_DEPTH = 400,
  parameter int RESET_PC   = 0,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instr,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  output logic        halted,
  output logic        pc_fault
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);
  localparam int          CNT_W    = $clog2(FIFO_DEPTH + 1);
  localparam logic [31:0] DEPTH_W  = 32'(IMEM_DEPTH);
  localparam logic [31:0] LAST_PC  = 32'(IMEM_DEPTH - 1);
  localparam logic [31:0] START_PC = 32'(RESET_PC);

  typedef enum logic {RUN, HALT} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_ent_t;

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic             fault_q, fault_d;
  logic             push, pop, flush;
  logic [CNT_W-1:0] count;
  fetch_ent_t       push_ent, head_ent;

  assign imem_pc   = pc_q;
  assign push_ent  = '{pc: pc_q, instr: imem_instr};
  assign dec_valid = (count != '0);
  assign dec_instr = head_ent.instr;
  assign dec_pc    = head_ent.pc;
  assign halted    = (state_q == HALT);
  assign pc_fault  = fault_q;

  fetch_fifo #(
    .WIDTH ($bits(fetch_ent_t)),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .push     (push),
    .push_dat (push_ent),
    .pop      (pop),
    .head_dat (head_ent),
    .count    (count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      pc_q    <= START_PC;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fault_d = fault_q;
    push    = 1'b0;
    pop     = 1'b0;
    flush   = 1'b0;
    if (redirect_valid) begin
      // Redirect wins over everything: drop buffered wrong-path words.
      flush = 1'b1;
      if (redirect_pc < DEPTH_W) begin
        pc_d    = redirect_pc;
        state_d = RUN;
      end else begin
        state_d = HALT;
        fault_d = 1'b1;
      end
    end else begin
      pop = dec_valid && dec_ready;
      if (state_q == RUN) begin
        if ((count < CNT_W'(FIFO_DEPTH)) || pop) begin
          push = 1'b1;
          if (pc_q == LAST_PC) state_d = HALT;
          else                 pc_d    = pc_q + 32'd1;
        end
        if (halt_req) state_d = HALT;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (push) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if ((state_q == RUN) && !push) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`else
  // No performance counters in this build.
`endif
endmodule
